breathing_pwm: RTL and testbench



---
 rtl/breathing_pwm.sv | 177 +++++++++++++++++
 tb/tb_breathing_pwm.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/breathing_pwm.sv
// breathing_pwm: triangular brightness envelope (rise, hold-high, fall,
// hold-low) driving an LED through a fixed-period PWM.
// Restart and mode come from the slow debounce domain and are re-synchronised.
// Duty only changes at a PWM period boundary, so each period uses one duty value.
// Optional feature: define BREATH_GAMMA_EN to pass duty through a squaring
// gamma curve, duty_eff = (duty*duty) >> PWM_BITS, before the PWM compare.
module breathing_pwm #(
    parameter int PWM_BITS     = 8,
    parameter int SLOW_PERIODS = 40,
    parameter int FAST_PERIODS = 10,
    parameter int HOLD_STEPS   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s4_in,
    input  logic                mode_in,
    output logic                led,
    output logic [PWM_BITS-1:0] duty,
    output logic [1:0]          phase,
    output logic                step_tick
);

    localparam int MAX_PERIODS = (SLOW_PERIODS > FAST_PERIODS) ? SLOW_PERIODS : FAST_PERIODS;
    localparam int STEP_W      = (MAX_PERIODS > 1) ? $clog2(MAX_PERIODS) : 1;
    localparam int HOLD_W      = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [PWM_BITS-1:0] DUTY_TOP1 = DUTY_MAX - 1'b1;
    localparam logic [STEP_W-1:0]   SLOW_LAST = STEP_W'(SLOW_PERIODS - 1);
    localparam logic [STEP_W-1:0]   FAST_LAST = STEP_W'(FAST_PERIODS - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    typedef enum logic [1:0] {
        RISE    = 2'd0,
        HOLD_HI = 2'd1,
        FALL    = 2'd2,
        HOLD_LO = 2'd3
    } phase_t;

    // Saturating duty increment: never wraps past full scale.
    function automatic logic [PWM_BITS-1:0] sat_inc(input logic [PWM_BITS-1:0] d);
        return (d == DUTY_MAX) ? d : d + 1'b1;
    endfunction

    // Saturating duty decrement: never wraps below zero.
    function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] d);
        return (d == '0) ? d : d - 1'b1;
    endfunction

`ifdef BREATH_GAMMA_EN
    // Square the duty at full double width, keep the upper half.
    function automatic logic [PWM_BITS-1:0] gamma_map(input logic [PWM_BITS-1:0] d);
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
        return sq[2*PWM_BITS-1:PWM_BITS];
    endfunction
`endif

    logic                s4_sync_p0, s4_sync_p1, s4_prev;
    logic                mode_sync_p0, mode_sync_p1;
    logic                restart;

    logic [PWM_BITS-1:0] pwm_cnt, pwm_cnt_nxt;
    logic [STEP_W-1:0]   step_cnt, step_last;
    logic                period_end, step_due;

    phase_t              state, state_nxt;
    logic [PWM_BITS-1:0] duty_q, duty_nxt, duty_eff;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;

    // Two-flop synchronisers for the slow-domain inputs plus the restart edge register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s4_sync_p0   <= 1'b0;
            s4_sync_p1   <= 1'b0;
            s4_prev      <= 1'b0;
            mode_sync_p0 <= 1'b0;
            mode_sync_p1 <= 1'b0;
        end else begin
            s4_sync_p0   <= s4_in;
            s4_sync_p1   <= s4_sync_p0;
            s4_prev      <= s4_sync_p1;
            mode_sync_p0 <= mode_in;
            mode_sync_p1 <= mode_sync_p0;
        end
    end

    // One-clock restart on the rising edge of the synchronised S4 level.
    assign restart = s4_sync_p1 & ~s4_prev;

    // PWM counter advance and step-rate decision for this clock.
    always_comb begin
        period_end  = &pwm_cnt;
        step_last   = mode_sync_p1 ? FAST_LAST : SLOW_LAST;
        step_due    = period_end && (step_cnt >= step_last);
        pwm_cnt_nxt = restart ? '0 : pwm_cnt + 1'b1;
    end

    // Envelope next-state: restart wins, otherwise advance only on a step.
    always_comb begin
        state_nxt = state;
        duty_nxt  = duty_q;
        hold_nxt  = hold_cnt;
        if (restart) begin
            state_nxt = RISE;
            duty_nxt  = '0;
            hold_nxt  = '0;
        end else if (step_due) begin
            case (state)
                RISE: begin
                    duty_nxt = sat_inc(duty_q);
                    if (duty_q >= DUTY_TOP1) begin
                        state_nxt = HOLD_HI;
                        hold_nxt  = '0;
                    end
                end
                HOLD_HI: begin
                    if (hold_cnt >= HOLD_LAST) state_nxt = FALL;
                    else                       hold_nxt  = hold_cnt + 1'b1;
                end
                FALL: begin
                    duty_nxt = sat_dec(duty_q);
                    if (duty_q <= PWM_BITS'(1)) begin
                        state_nxt = HOLD_LO;
                        hold_nxt  = '0;
                    end
                end
                HOLD_LO: begin
                    if (hold_cnt >= HOLD_LAST) state_nxt = RISE;
                    else                       hold_nxt  = hold_cnt + 1'b1;
                end
                default: state_nxt = RISE;
            endcase
        end
    end

    // The compare uses the duty that will be live for the next PWM cycle.
`ifdef BREATH_GAMMA_EN
    assign duty_eff = gamma_map(duty_nxt);
`else
    assign duty_eff = duty_nxt;
`endif

    // PWM counter, step divider, step strobe and registered LED drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt   <= '0;
            step_cnt  <= '0;
            step_tick <= 1'b0;
            led       <= 1'b0;
        end else begin
            pwm_cnt   <= pwm_cnt_nxt;
            step_tick <= step_due & ~restart;
            led       <= ~restart & (pwm_cnt_nxt < duty_eff);
            if (restart)          step_cnt <= '0;
            else if (step_due)    step_cnt <= '0;
            else if (period_end)  step_cnt <= step_cnt + 1'b1;
        end
    end

    // Envelope state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RISE;
            duty_q   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            duty_q   <= duty_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    assign duty  = duty_q;
    assign phase = state;

endmodule

// File: tb/tb_breathing_pwm.sv
// Directed bench for breathing_pwm with PWM_BITS=4, SLOW=4, FAST=2, HOLD=2.
// Expected envelope values come from the closed-form helpers below.
module tb_breathing_pwm;

    logic       clk;
    logic       rst_n;
    logic       s4_in;
    logic       mode_in;
    logic       led;
    logic [3:0] duty;
    logic [1:0] phase;
    logic       step_tick;

    int n_cmp = 0;
    int n_bad = 0;

    breathing_pwm #(
        .PWM_BITS    (4),
        .SLOW_PERIODS(4),
        .FAST_PERIODS(2),
        .HOLD_STEPS  (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s4_in    (s4_in),
        .mode_in  (mode_in),
        .led      (led),
        .duty     (duty),
        .phase    (phase),
        .step_tick(step_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Envelope position m in 1..34 repeats: 15 rise, 2 hold-high, 15 fall, 2 hold-low.
    function automatic int env_pos(input int k);
        return (k == 0) ? 0 : ((k - 1) % 34) + 1;
    endfunction

    function automatic int exp_duty(input int k);
        int m;
        m = env_pos(k);
        if (m <= 15) return m;
        if (m <= 17) return 15;
        if (m <= 32) return 32 - m;
        return 0;
    endfunction

    function automatic int exp_phase(input int k);
        int m;
        m = env_pos(k);
        if (m <= 14) return 0;
        if (m <= 16) return 1;
        if (m <= 31) return 2;
        if (m <= 33) return 3;
        return 0;
    endfunction

    // LED pattern over one 16-clk period: high from pwm_cnt=0 for the effective duty.
    function automatic logic [15:0] exp_pat(input int d);
        int e;
        logic [15:0] p;
`ifdef BREATH_GAMMA_EN
        e = (d * d) >> 4;
`else
        e = d;
`endif
        p = '0;
        for (int i = 0; i < e; i++) p[i] = 1'b1;
        return p;
    endfunction

    // Walk envelope steps k0..k1, each expected 'per' clocks after the previous one.
    task automatic run_steps(input int k0, input int k1, input int per);
        int n;
        logic [15:0] pat;
        for (int k = k0; k <= k1; k++) begin
            pat    = '0;
            pat[0] = led;
            n      = 0;
            do begin
                @(posedge clk); #1;
                n++;
                if (n < 16) pat[n] = led;
            end while (step_tick !== 1'b1 && n < per + 8);
            chk($sformatf("interval k=%0d", k), n, per);
            chk($sformatf("duty k=%0d", k), duty, exp_duty(k));
            chk($sformatf("phase k=%0d", k), phase, exp_phase(k));
            if ((k - 1) inside {3, 5, 8, 15, 32})
                chk($sformatf("pwm_pat duty=%0d", exp_duty(k - 1)), pat, exp_pat(exp_duty(k - 1)));
        end
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        s4_in   = 1'b0;
        mode_in = 1'b0;

        // Reset held with toggling inputs: all outputs stay cleared.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            s4_in   = ~s4_in;
            mode_in = i[0];
            chk("reset_outputs", {led, duty, phase, step_tick}, 0);
        end
        s4_in   = 1'b0;
        mode_in = 1'b1;
        rst_n   = 1'b1;

        // Fast mode: full envelope plus part of the next, ending mid-FALL at duty 9.
        run_steps(1, 57, 32);

        // Restart: S4 held high well beyond the debounce pulse length.
        s4_in = 1'b1;
        @(posedge clk); #1;
        chk("restart_edge1_duty", duty, 9);
        @(posedge clk); #1;
        chk("restart_edge2_duty", duty, 9);
        @(posedge clk); #1;
        chk("restart_edge3_duty", duty, 0);
        chk("restart_edge3_phase", phase, 0);
        chk("restart_edge3_led", led, 0);
        chk("restart_edge3_tick", step_tick, 0);
        run_steps(1, 31, 32);
        s4_in = 1'b0;

        // Slow mode: one step per four PWM periods.
        mode_in = 1'b0;
        run_steps(32, 33, 64);

        // Switch to fast mid-count (divider at 2): step at the next period end.
        n = 0;
        repeat (33) begin @(posedge clk); #1; n++; end
        mode_in = 1'b1;
        repeat (2) begin @(posedge clk); #1; n++; end
        chk("switch_duty_held", duty, exp_duty(33));
        chk("switch_phase_held", phase, exp_phase(33));
        while (step_tick !== 1'b1 && n < 80) begin @(posedge clk); #1; n++; end
        chk("switch_interval", n, 48);
        chk("switch_duty_k34", duty, exp_duty(34));
        chk("switch_phase_k34", phase, exp_phase(34));
        run_steps(35, 36, 32);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {led, duty, phase, step_tick}, 0);
        @(posedge clk); #1;
        chk("reset_hold_outputs", {led, duty, phase, step_tick}, 0);
        rst_n = 1'b1;
        run_steps(1, 2, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
